// File: rtl/usb_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_sequencer_if
//  Description : Bundle of the protocol-side command/FIFO signals and the
//                serializer-side byte/EOP handshake of the USB FS TX
//                sequencer. "slave" is the sequencer's view; "master" is the
//                view of the surrounding protocol controller and serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_sequencer_if;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       ser_ready;
    logic       eop_done;
    logic       get_tx_packet_data;
    logic       byte_load;
    logic [7:0] tx_byte;
    logic       eop_start;
    logic       tx_transfer_active;
    logic       tx_error;

    modport master (
        output tx_packet, buffer_occupancy, tx_packet_data, ser_ready, eop_done,
        input  get_tx_packet_data, byte_load, tx_byte, eop_start,
               tx_transfer_active, tx_error
    );

    modport slave (
        input  tx_packet, buffer_occupancy, tx_packet_data, ser_ready, eop_done,
        output get_tx_packet_data, byte_load, tx_byte, eop_start,
               tx_transfer_active, tx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_sequencer
//  Description : Packet-level controller of the USB full-speed transmit path.
//                Sequences SYNC, PID, payload, CRC16 and EOP into the byte
//                serializer, computes the data CRC16 on the fly and flags
//                protocol errors (illegal command, oversize payload, FIFO
//                underflow, handshake timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer #(
    parameter int unsigned MAX_DATA = 64,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    usb_tx_sequencer_if.slave   bus
);

    localparam logic [6:0] c_MAX_DATA  = 7'(MAX_DATA);
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_SYNC_BYTE = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_PID    = 4'd2,
        ST_DATA   = 4'd3,
        ST_CRC_LO = 4'd4,
        ST_CRC_HI = 4'd5,
        ST_EOP    = 4'd6,
        ST_ERR    = 4'd7
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [3:0]  r_pid,       w_pid_nxt;
    logic        r_is_data,   w_is_data_nxt;
    logic [6:0]  r_len,       w_len_nxt;
    logic [15:0] r_crc,       w_crc_nxt;
    logic [7:0]  r_wait,      w_wait_nxt;
    logic        r_eop_sent,  w_eop_sent_nxt;
    logic        r_byte_load, w_byte_load_nxt;
    logic [7:0]  r_tx_byte,   w_tx_byte_nxt;
    logic        r_get,       w_get_nxt;
    logic        r_eop_start, w_eop_start_nxt;
    logic        r_active,    w_active_nxt;
    logic        r_error,     w_error_nxt;

    logic        w_tick;
    logic        w_cmd_ok;
    logic        w_cmd_is_data;
    logic [3:0]  w_cmd_pid;

    // Reflected CRC16 (0xA001) advanced by one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Next-state and next-output decode; every registered output is computed here.
    always_comb begin
        w_state_nxt     = r_state;
        w_pid_nxt       = r_pid;
        w_is_data_nxt   = r_is_data;
        w_len_nxt       = r_len;
        w_crc_nxt       = r_crc;
        w_wait_nxt      = r_wait;
        w_eop_sent_nxt  = r_eop_sent;
        w_byte_load_nxt = 1'b0;
        w_tx_byte_nxt   = r_tx_byte;
        w_get_nxt       = 1'b0;
        w_eop_start_nxt = 1'b0;
        w_active_nxt    = r_active;
        w_error_nxt     = r_error;
        w_tick          = 1'b0;
        w_cmd_ok        = 1'b0;
        w_cmd_is_data   = 1'b0;
        w_cmd_pid       = 4'h0;

        case (r_state)
            ST_IDLE: begin
                w_crc_nxt      = 16'hFFFF;
                w_wait_nxt     = 8'd0;
                w_eop_sent_nxt = 1'b0;
                case (bus.tx_packet)
                    3'd1:    begin w_cmd_ok = 1'b1; w_cmd_is_data = 1'b1; w_cmd_pid = 4'h3; end
                    3'd2:    begin w_cmd_ok = 1'b1; w_cmd_is_data = 1'b1; w_cmd_pid = 4'hB; end
                    3'd3:    begin w_cmd_ok = 1'b1; w_cmd_pid = 4'h2; end
                    3'd4:    begin w_cmd_ok = 1'b1; w_cmd_pid = 4'hA; end
                    3'd5:    begin w_cmd_ok = 1'b1; w_cmd_pid = 4'hE; end
                    default: ;
                endcase
                if (bus.tx_packet != 3'd0) begin
                    if (w_cmd_ok && !(w_cmd_is_data && (bus.buffer_occupancy > c_MAX_DATA))) begin
                        w_state_nxt   = ST_SYNC;
                        w_pid_nxt     = w_cmd_pid;
                        w_is_data_nxt = w_cmd_is_data;
                        w_len_nxt     = w_cmd_is_data ? bus.buffer_occupancy : 7'd0;
                        w_active_nxt  = 1'b1;
                        w_error_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end

            ST_SYNC: begin
                if (bus.ser_ready) begin
                    w_byte_load_nxt = 1'b1;
                    w_tx_byte_nxt   = c_SYNC_BYTE;
                    w_wait_nxt      = 8'd0;
                    w_state_nxt     = ST_PID;
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_PID: begin
                if (bus.ser_ready) begin
                    w_byte_load_nxt = 1'b1;
                    w_tx_byte_nxt   = {~r_pid, r_pid};
                    w_wait_nxt      = 8'd0;
                    if (!r_is_data)
                        w_state_nxt = ST_EOP;
                    else if (r_len == 7'd0)
                        w_state_nxt = ST_CRC_LO;
                    else
                        w_state_nxt = ST_DATA;
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_DATA: begin
                // The cycle carrying a pop still shows the old FIFO head, so it is skipped.
                if (bus.ser_ready && !r_get) begin
                    w_wait_nxt = 8'd0;
                    if (bus.buffer_occupancy == 7'd0) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_EOP;
                    end else begin
                        w_byte_load_nxt = 1'b1;
                        w_get_nxt       = 1'b1;
                        w_tx_byte_nxt   = bus.tx_packet_data;
                        w_crc_nxt       = crc16_byte(r_crc, bus.tx_packet_data);
                        w_len_nxt       = r_len - 7'd1;
                        if (r_len == 7'd1)
                            w_state_nxt = ST_CRC_LO;
                    end
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_CRC_LO: begin
                if (bus.ser_ready) begin
                    w_byte_load_nxt = 1'b1;
                    w_tx_byte_nxt   = ~r_crc[7:0];
                    w_wait_nxt      = 8'd0;
                    w_state_nxt     = ST_CRC_HI;
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_CRC_HI: begin
                if (bus.ser_ready) begin
                    w_byte_load_nxt = 1'b1;
                    w_tx_byte_nxt   = ~r_crc[15:8];
                    w_wait_nxt      = 8'd0;
                    w_state_nxt     = ST_EOP;
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_EOP: begin
                if (!r_eop_sent) begin
                    if (bus.ser_ready) begin
                        w_eop_start_nxt = 1'b1;
                        w_eop_sent_nxt  = 1'b1;
                        w_wait_nxt      = 8'd0;
                    end else begin
                        w_tick = 1'b1;
                    end
                end else if (bus.eop_done) begin
                    w_wait_nxt   = 8'd0;
                    w_active_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_tick = 1'b1;
                end
            end

            ST_ERR: begin
                w_error_nxt  = 1'b1;
                w_active_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A cycle spent waiting on the serializer advances the watchdog.
        if (w_tick) begin
            if (r_wait == c_WAIT_LAST)
                w_state_nxt = ST_ERR;
            else
                w_wait_nxt = r_wait + 8'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pid       <= 4'h0;
            r_is_data   <= 1'b0;
            r_len       <= 7'd0;
            r_crc       <= 16'hFFFF;
            r_wait      <= 8'd0;
            r_eop_sent  <= 1'b0;
            r_byte_load <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_get       <= 1'b0;
            r_eop_start <= 1'b0;
            r_active    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pid       <= w_pid_nxt;
            r_is_data   <= w_is_data_nxt;
            r_len       <= w_len_nxt;
            r_crc       <= w_crc_nxt;
            r_wait      <= w_wait_nxt;
            r_eop_sent  <= w_eop_sent_nxt;
            r_byte_load <= w_byte_load_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_get       <= w_get_nxt;
            r_eop_start <= w_eop_start_nxt;
            r_active    <= w_active_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign bus.byte_load          = r_byte_load;
    assign bus.tx_byte            = r_tx_byte;
    assign bus.get_tx_packet_data = r_get;
    assign bus.eop_start          = r_eop_start;
    assign bus.tx_transfer_active = r_active;
    assign bus.tx_error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_sequencer
//  Description : Self-checking bench for usb_tx_sequencer. A transaction-level
//                model predicts the byte stream, FIFO pops, EOP requests and
//                error flag of each packet; a cycle loop plays the FIFO and
//                serializer with random ready/EOP latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

    localparam int c_MAX_DATA = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    usb_tx_sequencer_if bus ();

    usb_tx_sequencer #(.MAX_DATA(64), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC over the whole payload.
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [2:0] cmd);
        logic [7:0] tbl [0:5];
        tbl = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};
        return tbl[cmd];
    endfunction

    // One packet: cmd, n_fifo bytes queued, FIFO flushed after drain_after pops
    // (-1: never), ser_ready probability, ser_ready forced low once stall_after
    // bytes seen (-1: never), junk commands while busy.
    task automatic run_packet(input string name, input logic [2:0] cmd, input int n_fifo,
                              input int drain_after, input int ready_pct,
                              input int stall_after, input bit junk);
        logic [7:0]  fifo[$];
        logic [7:0]  sent[$];
        logic [7:0]  exp_b[$];
        logic [7:0]  got_b[$];
        logic [15:0] crc;
        bit          is_data, exp_err, seen_active, finished;
        int          exp_gets, exp_eops, n_sent;
        int          gets, eops, pops, cyc, done_cnt, done_cyc, end_cyc;

        for (int i = 0; i < n_fifo; i++) fifo.push_back(8'($urandom_range(0, 255)));
        is_data = (cmd == 3'd1) || (cmd == 3'd2);

        exp_err = 1'b0; exp_gets = 0; exp_eops = 0;
        if (cmd > 3'd5 || (is_data && n_fifo > c_MAX_DATA)) begin
            exp_err = 1'b1;
        end else if (stall_after == 1) begin
            exp_err = 1'b1;
            exp_b.push_back(8'h80);
        end else begin
            exp_b.push_back(8'h80);
            exp_b.push_back(pid_byte(cmd));
            exp_eops = 1;
            if (is_data) begin
                n_sent = (drain_after >= 0 && drain_after < n_fifo) ? drain_after : n_fifo;
                for (int i = 0; i < n_sent; i++) begin
                    sent.push_back(fifo[i]);
                    exp_b.push_back(fifo[i]);
                end
                exp_gets = n_sent;
                if (n_sent < n_fifo) begin
                    exp_err = 1'b1;
                end else begin
                    crc = ~ref_crc(sent);
                    exp_b.push_back(crc[7:0]);
                    exp_b.push_back(crc[15:8]);
                end
            end
        end

        gets = 0; eops = 0; pops = 0; cyc = 0; done_cnt = -1; done_cyc = -10; end_cyc = -1;
        seen_active = 1'b0; finished = 1'b0;
        @(negedge clk);
        bus.tx_packet        = cmd;
        bus.buffer_occupancy = 7'(fifo.size());
        bus.tx_packet_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        bus.ser_ready        = ($urandom_range(1, 100) <= ready_pct);
        bus.eop_done         = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus.byte_load) got_b.push_back(bus.tx_byte);
            if (bus.get_tx_packet_data) begin
                gets++;
                pops++;
                if (fifo.size() > 0) void'(fifo.pop_front());
            end
            if (drain_after >= 0 && pops >= drain_after) fifo.delete();
            if (bus.eop_start) begin
                eops++;
                done_cnt = $urandom_range(0, 3);
            end
            if (bus.tx_transfer_active) seen_active = 1'b1;
            if ((seen_active && !bus.tx_transfer_active) ||
                (!seen_active && bus.tx_error && cyc >= 3)) begin
                finished = 1'b1;
                end_cyc  = cyc;
            end
            bus.eop_done = 1'b0;
            if (done_cnt == 0) begin
                bus.eop_done = 1'b1;
                done_cnt     = -1;
                done_cyc     = cyc;
            end else if (done_cnt > 0) begin
                done_cnt--;
            end
            if (stall_after >= 0 && got_b.size() >= stall_after)
                bus.ser_ready = 1'b0;
            else
                bus.ser_ready = ($urandom_range(1, 100) <= ready_pct);
            bus.tx_packet = (junk && eops == 0 && bus.tx_transfer_active) ?
                            3'($urandom_range(0, 7)) : 3'd0;
            bus.buffer_occupancy = 7'(fifo.size());
            bus.tx_packet_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
        bus.tx_packet = 3'd0;
        bus.eop_done  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.byte_load) got_b.push_back(bus.tx_byte);
            if (bus.get_tx_packet_data) gets++;
            if (bus.eop_start) eops++;
        end
        bus.buffer_occupancy = 7'd0;

        check({name, " finished"}, int'(finished), 1);
        check({name, " nbytes"}, got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
            check($sformatf("%s byte%0d", name, i), int'(got_b[i]), int'(exp_b[i]));
        check({name, " gets"}, gets, exp_gets);
        check({name, " eops"}, eops, exp_eops);
        check({name, " tx_error"}, int'(bus.tx_error), int'(exp_err));
        check({name, " active_end"}, int'(bus.tx_transfer_active), 0);
        if (exp_eops == 1)
            check({name, " active_drop"}, end_cyc, done_cyc + 1);
    endtask

    initial begin
        int cmd, n, drain, pct;
        bus.tx_packet        = 3'd0;
        bus.buffer_occupancy = 7'd0;
        bus.tx_packet_data   = 8'h00;
        bus.ser_ready        = 1'b0;
        bus.eop_done         = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst byte_load", int'(bus.byte_load), 0);
        check("rst get", int'(bus.get_tx_packet_data), 0);
        check("rst eop_start", int'(bus.eop_start), 0);
        check("rst active", int'(bus.tx_transfer_active), 0);
        check("rst tx_error", int'(bus.tx_error), 0);
        check("rst tx_byte", int'(bus.tx_byte), 0);

        run_packet("ack",        3'd3, 0,  -1, 100, -1, 1'b0);
        run_packet("data0_zero", 3'd1, 0,  -1, 100, -1, 1'b0);
        run_packet("data1_3",    3'd2, 3,  -1, 100, -1, 1'b0);
        run_packet("underflow",  3'd1, 4,   2, 100, -1, 1'b0);
        run_packet("illegal7",   3'd7, 0,  -1, 100, -1, 1'b0);
        run_packet("nak_clear",  3'd4, 0,  -1,  60, -1, 1'b1);
        run_packet("over70",     3'd1, 70, -1, 100, -1, 1'b0);
        run_packet("over65",     3'd2, 65, -1, 100, -1, 1'b0);
        run_packet("max64",      3'd1, 64, -1,  70, -1, 1'b1);
        run_packet("stall_pid",  3'd5, 0,  -1, 100,  1, 1'b0);
        run_packet("stall_ok",   3'd5, 0,  -1,  50, -1, 1'b0);

        // Reset while payload bytes are flowing.
        @(negedge clk);
        bus.tx_packet        = 3'd1;
        bus.buffer_occupancy = 7'd10;
        bus.tx_packet_data   = 8'hA5;
        bus.ser_ready        = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            bus.tx_packet = 3'd0;
            if (bus.get_tx_packet_data) n++;
        end
        check("rstmid reached", n, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid byte_load", int'(bus.byte_load), 0);
        check("rstmid get", int'(bus.get_tx_packet_data), 0);
        check("rstmid active", int'(bus.tx_transfer_active), 0);
        check("rstmid tx_byte", int'(bus.tx_byte), 0);
        rst = 1'b0;
        bus.buffer_occupancy = 7'd0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.eop_start || bus.byte_load) n++;
        end
        check("rstmid quiet", n, 0);

        for (int k = 0; k < 20; k++) begin
            cmd   = $urandom_range(1, 5);
            n     = (cmd <= 2) ? $urandom_range(0, 64) : $urandom_range(0, 10);
            drain = (cmd <= 2 && n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            pct   = $urandom_range(30, 100);
            run_packet($sformatf("rand%0d", k), 3'(cmd), n, drain, pct, -1, drain < 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
